mul_fp16_arbiter: RTL and testbench

Shares one pipelined `mul_fp16` unit between `NUM_REQ` requesters, such as tensor-core lanes or an accumulate sequencer. Each cycle, a round-robin arbiter grants at most one valid request and issues its operands to the multiplier. A tag pipeline tracks the requester ID of every in-flight product. Each result is returned `MUL_LATENCY` cycles later, tagged with that ID.

---
 rtl/mul_fp16_arbiter_pkg.sv | 15 +
 rtl/mul_fp16_arbiter_if.sv | 38 +++
 rtl/mul_fp16.sv | 72 +++++++
 rtl/mul_fp16_arbiter_rr_arbiter.sv | 28 ++
 rtl/mul_fp16_arbiter.sv | 92 +++++++++
 tb/tb_mul_fp16_arbiter.sv | 209 ++++++++++++++++++++
 6 files changed

// File: rtl/mul_fp16_arbiter_pkg.sv
// rtl/mul_fp16_arbiter_pkg.sv - shared types and constants for the shared FP16 multiplier arbiter
package mul_arb_pkg;

    typedef logic [15:0] fp16_t;

    localparam int MUL_FP16_LATENCY = 3;
    // Wide enough for the largest supported requester count (16).
    localparam int MUL_TAG_ID_W = 4;

    typedef struct packed {
        logic                    valid;
        logic [MUL_TAG_ID_W-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/mul_fp16_arbiter_if.sv
// rtl/mul_fp16_arbiter_if.sv - requester/response bundle; perf signals exist only with MUL_ARB_PERF_EN
interface mul_fp16_arbiter_if
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    fp16_t                 rsp_result;
    logic                  busy;
`ifdef MUL_ARB_PERF_EN
    logic [31:0]           perf_issued;
    logic [31:0]           perf_stalls;
`endif

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_result, busy
`ifdef MUL_ARB_PERF_EN
        , input perf_issued, perf_stalls
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_result, busy
`ifdef MUL_ARB_PERF_EN
        , output perf_issued, perf_stalls
`endif
    );

endinterface

// File: rtl/mul_fp16.sv
// rtl/mul_fp16.sv - pipelined FP16 multiplier, round-to-nearest-even
// Subnormal inputs and results flush to signed zero; NaN results are the canonical 0x7E00.
module mul_fp16
    import mul_arb_pkg::*;
#(
    parameter int LATENCY = MUL_FP16_LATENCY
) (
    input  logic  clk,
    input  logic  nRST,
    input  logic  start,
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t result,
    output logic  done
);
    logic        w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [21:0] w_prod;
    logic [9:0]  w_mant;
    logic        w_guard, w_sticky;
    logic [10:0] w_mrnd;
    logic [6:0]  w_esum, w_efin;
    fp16_t       w_res;
    fp16_t       r_res [LATENCY];
    logic [LATENCY-1:0] r_done;

    assign w_sign   = a[15] ^ b[15];
    assign w_a_zero = (a[14:10] == 5'd0);
    assign w_b_zero = (b[14:10] == 5'd0);
    assign w_a_inf  = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
    assign w_b_inf  = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
    assign w_a_nan  = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
    assign w_b_nan  = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
    assign w_prod   = {1'b1, a[9:0]} * {1'b1, b[9:0]};

    // Exponents stay biased by +15 until the final range check.
    always_comb begin
        w_esum   = 7'(a[14:10]) + 7'(b[14:10]) + 7'(w_prod[21]);
        w_mant   = w_prod[21] ? w_prod[20:11] : w_prod[19:10];
        w_guard  = w_prod[21] ? w_prod[10] : w_prod[9];
        w_sticky = w_prod[21] ? (|w_prod[9:0]) : (|w_prod[8:0]);
        w_mrnd   = {1'b0, w_mant} + 11'(w_guard & (w_sticky | w_mant[0]));
        w_efin   = w_esum + 7'(w_mrnd[10]);
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            w_res = 16'h7E00;
        else if (w_a_inf || w_b_inf)
            w_res = {w_sign, 15'h7C00};
        else if (w_a_zero || w_b_zero || (w_efin <= 7'd15))
            w_res = {w_sign, 15'h0000};
        else if (w_efin >= 7'd46)
            w_res = {w_sign, 15'h7C00};
        else
            w_res = {w_sign, 5'(w_efin - 7'd15), w_mrnd[9:0]};
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < LATENCY; i++) r_res[i] <= '0;
            r_done <= '0;
        end else begin
            r_res[0]  <= w_res;
            r_done[0] <= start;
            for (int i = 1; i < LATENCY; i++) begin
                r_res[i]  <= r_res[i-1];
                r_done[i] <= r_done[i-1];
            end
        end
    end

    assign result = r_res[LATENCY-1];
    assign done   = r_done[LATENCY-1];

endmodule

// File: rtl/mul_fp16_arbiter_rr_arbiter.sv
// rtl/mul_fp16_arbiter_rr_arbiter.sv - combinational round-robin grant, search starts after last
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id
);
    logic                 w_found;
    logic [$clog2(N)-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = $clog2(N)'((int'(last) + k) % N);
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/mul_fp16_arbiter.sv
// rtl/mul_fp16_arbiter.sv - round-robin sharing of one mul_fp16 with tagged responses; MUL_ARB_PERF_EN adds perf counters
module mul_fp16_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = MUL_FP16_LATENCY
) (
    input logic               clk,
    input logic               nRST,
    mul_fp16_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    r_last_grant;
    mul_tag_t           r_tag [MUL_LATENCY];
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_start;
    logic               w_busy;
    logic               w_done;
    fp16_t              w_a, w_b, w_result;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req    (bus.req_valid),
        .last   (r_last_grant),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign w_start = |w_gnt;
    // Idle cycles feed zeros so the multiplier pipe carries a clean 0 instead of stale operands.
    assign w_a = w_start ? bus.req_a[int'(w_gnt_id)*16 +: 16] : '0;
    assign w_b = w_start ? bus.req_b[int'(w_gnt_id)*16 +: 16] : '0;

    mul_fp16 #(.LATENCY(MUL_LATENCY)) u_mul (
        .clk    (clk),
        .nRST   (nRST),
        .start  (w_start),
        .a      (w_a),
        .b      (w_b),
        .result (w_result),
        .done   (w_done)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            for (int i = 0; i < MUL_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            if (w_start) r_last_grant <= w_gnt_id;
            r_tag[0].valid <= w_start;
            r_tag[0].id    <= MUL_TAG_ID_W'(w_gnt_id);
            for (int i = 1; i < MUL_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < MUL_LATENCY; i++) w_busy = w_busy | r_tag[i].valid;
    end

    assign bus.req_ready  = w_gnt;
    assign bus.rsp_valid  = r_tag[MUL_LATENCY-1].valid;
    assign bus.rsp_id     = r_tag[MUL_LATENCY-1].id[ID_W-1:0];
    assign bus.rsp_result = w_result;
    assign bus.busy       = w_busy;

    // The tag pipe and the multiplier's own done pipe must stay in lockstep.
    a_done_matches_tag: assert property (@(posedge clk) disable iff (!nRST)
        w_done == r_tag[MUL_LATENCY-1].valid);

`ifdef MUL_ARB_PERF_EN
    logic [31:0] r_perf_issued, r_perf_stalls;
    logic [32:0] w_stall_sum;

    assign w_stall_sum = {1'b0, r_perf_stalls} + 33'($countones(bus.req_valid & ~w_gnt));

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_perf_issued <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_start) r_perf_issued <= r_perf_issued + 32'd1;
            r_perf_stalls <= w_stall_sum[32] ? 32'hFFFF_FFFF : w_stall_sum[31:0];
        end
    end

    assign bus.perf_issued = r_perf_issued;
    assign bus.perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_mul_fp16_arbiter.sv
// tb/tb_mul_fp16_arbiter.sv - directed vector bench for mul_fp16_arbiter (perf checks with MUL_ARB_PERF_EN)
module tb_mul_fp16_arbiter;
    localparam int NR = 4;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mul_fp16_arbiter_if #(.NUM_REQ(NR)) bus ();

    mul_fp16_arbiter #(.NUM_REQ(NR), .MUL_LATENCY(3)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nRST) check("done_eq_rsp_valid", 32'(dut.u_mul.done), 32'(bus.rsp_valid));
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"},  32'(bus.req_ready),  32'h0);
        check({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'h0);
        check({tag, "_rsp_id"},     32'(bus.rsp_id),     32'h0);
        check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'h0);
        check({tag, "_busy"},       32'(bus.busy),       32'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        nRST = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
    endtask

    vec_t        vecs [9];
    logic [15:0] all_a [4];
    logic [15:0] all_b [4];
    logic [15:0] all_p [4];
    int          g0, g3, n_rsp, n_id1;

    initial begin
        vecs[0] = '{2, 16'h3C00, 16'h4000, 16'h4000};
        vecs[1] = '{0, 16'h3E00, 16'h3E00, 16'h4080};
        vecs[2] = '{1, 16'hC000, 16'h4200, 16'hC600};
        vecs[3] = '{3, 16'h0000, 16'h4000, 16'h0000};
        vecs[4] = '{1, 16'h7C00, 16'h4000, 16'h7C00};
        vecs[5] = '{2, 16'h7BFF, 16'h4000, 16'h7C00};
        vecs[6] = '{0, 16'h3555, 16'h4200, 16'h3C00};
        vecs[7] = '{2, 16'hBC00, 16'hBC00, 16'h3C00};
        vecs[8] = '{3, 16'h4400, 16'h4500, 16'h4D00};
        all_a = '{16'h3E00, 16'hC000, 16'h0000, 16'h3C00};
        all_b = '{16'h3E00, 16'h4200, 16'h4000, 16'h3C00};
        all_p = '{16'h4080, 16'hC600, 16'h0000, 16'h3C00};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef MUL_ARB_PERF_EN
        check("reset_perf_issued", bus.perf_issued, 32'd0);
        check("reset_perf_stalls", bus.perf_stalls, 32'd0);
`endif
        @(negedge clk);
        nRST = 1'b1;

        // Single requests: grant, latency, busy window, product.
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            bus.req_valid = 4'(1 << vecs[v].id);
            bus.req_a[vecs[v].id*16 +: 16] = vecs[v].a;
            bus.req_b[vecs[v].id*16 +: 16] = vecs[v].b;
            #1;
            check("tbl_ready", 32'(bus.req_ready), 32'(1 << vecs[v].id));
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            check("tbl_t1_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            check("tbl_t1_busy",      32'(bus.busy),      32'h1);
            repeat (2) @(negedge clk);
            #1;
            check("tbl_rsp_valid",  32'(bus.rsp_valid),  32'h1);
            check("tbl_rsp_id",     32'(bus.rsp_id),     32'(vecs[v].id));
            check("tbl_rsp_result", 32'(bus.rsp_result), 32'(vecs[v].p));
            check("tbl_t3_busy",    32'(bus.busy),       32'h1);
            @(negedge clk);
            #1;
            check("tbl_t4_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            check("tbl_t4_busy",      32'(bus.busy),      32'h0);
        end

        // All four at once: grants 0..3 back to back, responses in issue order.
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*16 +: 16] = all_a[i];
            bus.req_b[i*16 +: 16] = all_b[i];
        end
        bus.req_valid = 4'hF;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (k < 4) check("all_ready", 32'(bus.req_ready), 32'(1 << k));
            if (k >= 3) begin
                check("all_rsp_valid",  32'(bus.rsp_valid),  32'h1);
                check("all_rsp_id",     32'(bus.rsp_id),     32'(k - 3));
                check("all_rsp_result", 32'(bus.rsp_result), 32'(all_p[k-3]));
            end
            @(negedge clk);
            if (k < 4) bus.req_valid[k] = 1'b0;
        end
        #1;
        check("all_drained", 32'(bus.rsp_valid), 32'h0);

        // Fairness between requesters 0 and 3.
        pulse_reset();
        g0 = 0;
        g3 = 0;
        bus.req_valid = 4'b1001;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("fair_grant", 32'(bus.req_ready), (c % 2 == 0) ? 32'h1 : 32'h8);
            if (bus.req_ready[0]) g0++;
            if (bus.req_ready[3]) g3++;
            @(negedge clk);
        end
        bus.req_valid = '0;
        #1;
        check("fair_count0", 32'(g0), 32'd10);
        check("fair_count3", 32'(g3), 32'd10);
`ifdef MUL_ARB_PERF_EN
        check("fair_perf_issued", bus.perf_issued, 32'd20);
        check("fair_perf_stalls", bus.perf_stalls, 32'd20);
`endif
        repeat (5) @(negedge clk);

        // Requester 1 drops its request after losing to requester 0.
        bus.req_a[15:0] = 16'h3C00;
        bus.req_b[15:0] = 16'h3C00;
        bus.req_valid   = 4'b0011;
        #1;
        check("drop_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        n_rsp = 0;
        n_id1 = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.rsp_valid) begin
                n_rsp++;
                if (bus.rsp_id == 2'd1) n_id1++;
            end
            @(negedge clk);
        end
        check("drop_no_id1", 32'(n_id1), 32'd0);
        check("drop_one_rsp", 32'(n_rsp), 32'd1);

        // Reset with two products in flight.
        bus.req_valid = 4'b0010;
        #1;
        check("rst_issue1", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 4'b0100;
        #1;
        check("rst_issue2", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = '0;
        nRST = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(negedge clk);
        nRST  = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.rsp_valid) n_rsp++;
            @(negedge clk);
        end
        check("midrst_no_rsp", 32'(n_rsp), 32'd0);
        bus.req_valid = 4'hF;
        #1;
        check("midrst_first_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
